// File: rtl/tawas_sched_pkg.sv
// Shared constants for the Tawas thread scheduler: control register map and counter width.
package tawas_sched_pkg;
   localparam logic [1:0] SCHED_RUN    = 2'd0;
   localparam logic [1:0] SCHED_STOP   = 2'd1;
   localparam logic [1:0] SCHED_BUSY   = 2'd2;
   localparam logic [1:0] SCHED_STATUS = 2'd3;

   localparam int STATUS_ERR_BIT = 31;
   localparam int ISSUE_CNT_W    = 16;
endpackage

// File: rtl/tawas_rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Rotate so ptr lands at bit 0, priority-encode the lowest bit, then add ptr back.
module tawas_rr_pick #(
   parameter int NTHREADS = 32,
   parameter int TW       = 5
) (
   input  logic [NTHREADS-1:0] req,
   input  logic [TW-1:0]       ptr,
   output logic                vld,
   output logic [TW-1:0]       idx
);

   logic [NTHREADS-1:0] rot;
   logic [TW-1:0]       off;

   always_comb begin
      rot = NTHREADS'({req, req} >> ptr);
      off = '0;
      for (int i = NTHREADS - 1; i >= 0; i--) begin
         if (rot[i]) off = TW'(i);
      end
      vld = |req;
      idx = ptr + off;
   end

endmodule

// File: rtl/tawas_thread_sched.sv
// Round-robin thread issue for the fetch pipeline; one issue per cycle, output registered (1 cycle).
// stall only suppresses issue; retire, wake and control accesses are still processed.
module tawas_thread_sched
   import tawas_sched_pkg::*;
#(
   parameter int          NTHREADS  = 32,
   parameter int          TW        = 5,
   parameter logic [31:0] RESET_RUN = 32'h0000_0001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   output logic                sched_en,
   output logic [TW-1:0]       sched_sel,
   input  logic                retire_en,
   input  logic [TW-1:0]       retire_thread,
   input  logic                retire_halt,
   input  logic [NTHREADS-1:0] wake,
   input  logic                ctl_wr,
   input  logic                ctl_rd,
   input  logic [1:0]          ctl_addr,
   input  logic [31:0]         ctl_wdata,
   output logic [31:0]         ctl_rdata,
   output logic [NTHREADS-1:0] run_mask
);

   logic [NTHREADS-1:0]    run, busy, eligible, run_nxt, busy_nxt, wmask;
   logic [TW-1:0]          rr_ptr, pick;
   logic                   pick_vld, issue, ret_ok, ret_bad, err;
   logic [ISSUE_CNT_W-1:0] issue_cnt;
   logic [31:0]            rd_mux;

   assign eligible = run & ~busy;
   assign run_mask = run;
   assign wmask    = ctl_wdata[NTHREADS-1:0];

   tawas_rr_pick #(.NTHREADS(NTHREADS), .TW(TW)) u_pick (
      .req (eligible),
      .ptr (rr_ptr),
      .vld (pick_vld),
      .idx (pick)
   );

   always_comb begin
      issue   = pick_vld & ~stall;
      ret_ok  = retire_en & busy[retire_thread];
      ret_bad = retire_en & ~busy[retire_thread];

      // Clear before set: a same-thread issue/retire collision leaves the thread busy.
      busy_nxt = busy;
      if (ret_ok) busy_nxt[retire_thread] = 1'b0;
      if (issue)  busy_nxt[pick] = 1'b1;

      // Later assignments win: halt < wake < RUN write < STOP write.
      run_nxt = run;
      if (ret_ok && retire_halt)             run_nxt[retire_thread] = 1'b0;
      run_nxt = run_nxt | wake;
      if (ctl_wr && ctl_addr == SCHED_RUN)   run_nxt = run_nxt | wmask;
      if (ctl_wr && ctl_addr == SCHED_STOP)  run_nxt = run_nxt & ~wmask;

      rd_mux = '0;
      case (ctl_addr)
         SCHED_RUN:  rd_mux = 32'(run);
         SCHED_BUSY: rd_mux = 32'(busy);
         SCHED_STATUS: begin
            rd_mux[STATUS_ERR_BIT]    = err;
            rd_mux[ISSUE_CNT_W-1:0]   = issue_cnt;
         end
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run       <= RESET_RUN[NTHREADS-1:0];
         busy      <= '0;
         rr_ptr    <= '0;
         sched_en  <= 1'b0;
         sched_sel <= '0;
         ctl_rdata <= '0;
         issue_cnt <= '0;
         err       <= 1'b0;
      end else begin
         run  <= run_nxt;
         busy <= busy_nxt;
         if (issue) begin
            sched_en  <= 1'b1;
            sched_sel <= pick;
            rr_ptr    <= pick + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
         end else begin
            sched_en  <= 1'b0;
         end
         if (ret_bad)
            err <= 1'b1;
         else if (ctl_wr && ctl_addr == SCHED_STATUS && ctl_wdata[STATUS_ERR_BIT])
            err <= 1'b0;
         if (ctl_rd) ctl_rdata <= rd_mux;
      end
   end

endmodule

// File: doc/tawas_thread_sched.md
Name: tawas_thread_sched

Overview:
Round-robin thread scheduler for the Tawas fetch pipeline. It replaces the fixed-priority "lowest non-busy thread" pick with a fair pick among threads that are both runnable and not in flight. It tracks per-thread run/busy state, retires threads on the pipeline retire strobe, and turns halt instructions into run-bit clears. A small control register port lets software start, stop and monitor threads.

Parameters:
NTHREADS, 32, number of hardware threads; must be a power of two, max 32
TW, 5, thread index width, log2(NTHREADS)
RESET_RUN, 32'h0000_0001, run bitmap value at reset (thread 0 boots)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  suppress issue this cycle
sched_en  out  1  registered issue strobe to fetch stage s2
sched_sel  out  TW  registered issued thread index
retire_en  in  1  thread leaving pipeline (fetch s6)
retire_thread  in  TW  retiring thread index
retire_halt  in  1  qualifies retire_en: thread executed halt
wake  in  NTHREADS  per-thread event pulses; each set bit sets that thread's run bit
ctl_wr  in  1  control write strobe
ctl_rd  in  1  control read strobe
ctl_addr  in  2  register select
ctl_wdata  in  32  write data
ctl_rdata  out  32  read data, valid the cycle after ctl_rd
run_mask  out  NTHREADS  current run bitmap (debug/observe)

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: run=RESET_RUN, busy=0, rr_ptr=0, sched_en=0, sched_sel=0, ctl_rdata=0, issue_cnt=0, err=0.
- eligible = run & ~busy. No bypass: a thread retiring in cycle N is not eligible until cycle N+1.
- Pick: the first eligible index scanning upward from rr_ptr, wrapping modulo NTHREADS.
- If the pick exists and !stall, on the edge:
  - sched_en<=1, sched_sel<=pick.
  - busy[pick]<=1, rr_ptr<=pick+1 (wraps).
  - issue_cnt<=issue_cnt+1 (16-bit, wraps).
- Otherwise sched_en<=0; sched_sel holds; rr_ptr holds.
- Issue-to-output latency is 1 cycle. At most one issue per cycle.
- Retire: retire_en clears busy[retire_thread].
  - With retire_halt also set, it clears run[retire_thread].
  - Retire of a thread whose busy bit is 0 is ignored for state and sets sticky err.
- Same-edge issue and retire of different threads: both take effect.
- Same-edge issue and retire of the same thread is impossible with no bypass; if it occurs, err is set and busy ends at 1.
- Run bit update priority, lowest to highest: halt clear, wake set, ctl RUN set, ctl STOP clear. The highest-priority source wins per bit.
- Stopping a busy thread does not abort it. It finishes its in-flight instruction and retires normally; it is simply not re-issued.
- Control registers (ctl_addr):
  - 0 RUN: read returns run; write sets run |= wdata.
  - 1 STOP: read returns 0; write clears run &= ~wdata.
  - 2 BUSY: read-only, returns busy; writes ignored.
  - 3 STATUS: read returns {err, 15'b0, issue_cnt}; a write with wdata[31]=1 clears err.
- Bits at or above NTHREADS read as 0 and ignore writes.
- ctl_rdata is registered. It updates only on ctl_rd and holds otherwise. Same-cycle write and read of the same register returns the pre-write value.
- stall only blocks issue; retire, wake and ctl are processed during stall.
- Reset mid-operation: busy is forced to 0. A retire arriving during rst is ignored. A stale retire after rst deasserts sets err and does not corrupt busy.

Decomposition:
- Package tawas_sched_pkg holds:
  - register offsets SCHED_RUN=0, SCHED_STOP=1, SCHED_BUSY=2, SCHED_STATUS=3;
  - STATUS_ERR_BIT=31;
  - the issue_cnt width constant.
- Sub-module tawas_rr_pick: purely combinational rotate-priority-encoder. Inputs req[NTHREADS] and ptr[TW]; outputs vld and idx[TW]. Implemented as rotate, priority-encode, add ptr.
- Scheduler top holds all registers, retire/wake/ctl logic and counters.

Test Plan:
- Boot: release rst with RESET_RUN=1, no retires -> cycle 1 sched_en=1, sel=0; cycles 2+ sched_en=0 until retire_en, thread 0 observed; thread 0 is re-issued 1 cycle after its retire.
- Round-robin: write RUN=32'h0000_0F00, retire each issue 5 cycles later -> issue order 8,9,10,11,8,9,... and no thread twice in a row while others are eligible.
- Wrap: run bits 31 and 1, rr_ptr past 31 -> order 31,1,31,1; STATUS issue_cnt increments by exactly 1 per sched_en, wraps 16'hFFFF->0.
- Halt/wake: thread 9 retires with retire_halt=1 -> run[9]=0 and thread 9 not issued; pulse wake[9] -> thread 9 issued within one rotation.
- Priority: same cycle retire_halt on thread 3 and ctl_wr RUN=32'h8 -> run[3]=1; same cycle wake[4] and STOP write 32'h10 -> run[4]=0.
- Errors/stall: retire_en for non-busy thread 20 -> STATUS bit31=1, BUSY unchanged; write STATUS 32'h8000_0000 -> bit31=0. Hold stall 4 cycles -> sched_en=0 throughout while retires still clear BUSY bits. Assert rst mid-stream -> BUSY reads 0 after reset.
